seqgen: RTL

- Serial sequence generator: the transmit-side counterpart of the team's serial pattern detector (the seqdet block).
- On a start request it captures a WIDTH-bit pattern and repeat count, then shifts the pattern out MSB-first on the serial line x, one bit per clk, REP times back-to-back.
- Used as stimulus source for seqdet on the board and as a standalone pattern transmitter.

---
 rtl/seqgen_pkg.sv | 13 +
 rtl/seqgen_piso.sv | 30 +++
 rtl/seqgen.sv | 112 +++++++++++
 3 files changed

// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial sequence generator and its companion detector.
// The state encoding is also shown on the debug LEDs, so both blocks must agree on it.
package seqgen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] PAT_1010 = 4'b1010;

endpackage

// File: rtl/seqgen_piso.sv
// Parallel-load, rotate-left shift register.
// It exposes the current MSB and the bit that becomes the MSB after the next rotate.
module seqgen_piso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb,
  output logic             nxt
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], q[WIDTH-1]};
    end
  end

  assign msb = q[WIDTH-1];
  assign nxt = q[WIDTH-2];

endmodule

// File: rtl/seqgen.sv
// Serial sequence generator: sends a captured pattern MSB-first, repeated rep times back-to-back.
// x and x_valid are flopped from next-state values, so the first bit appears one clock after start.
module seqgen
  import seqgen_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] rep,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       c_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  // A repeat count of zero still sends the pattern once.
  function automatic logic [REP_W-1:0] rep_sat(input logic [REP_W-1:0] r);
    return (r == '0) ? REP_W'(1) : r;
  endfunction

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt, bit_next;
  logic [REP_W-1:0] rep_cnt, rep_next;
  logic             load, shift, msb, nxt;
  logic             x_next, x_valid_next;

  seqgen_piso #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (pattern),
    .msb   (msb),
    .nxt   (nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_next;
      rep_cnt <= rep_next;
      x       <= x_next;
      x_valid <= x_valid_next;
    end
  end

  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    rep_next   = rep_cnt;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          rep_next   = rep_sat(rep);
          bit_next   = BIT_LAST;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else begin
          shift = 1'b1;
          if (bit_cnt == '0) begin
            // The register has rotated a full turn, so the next repetition needs no reload.
            if (rep_cnt > REP_W'(1)) begin
              rep_next = rep_cnt - REP_W'(1);
              bit_next = BIT_LAST;
            end else begin
              state_next = S_DONE;
            end
          end else begin
            bit_next = bit_cnt - CNT_W'(1);
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    x_next       = 1'b0;
    x_valid_next = (state_next == S_SHIFT);
    if (state_next == S_SHIFT) begin
      x_next = load ? pattern[WIDTH-1] : (shift ? nxt : msb);
    end
  end

  assign busy    = (state == S_SHIFT) || (state == S_DONE);
  assign done    = (state == S_DONE);
  assign c_state = state;

endmodule
